// File: rtl/dpram_pkg.sv
// rtl/dpram_pkg.sv - shared state type and policy constants for dual_port_ram_param
package dpram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } dpram_state_e;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;
  localparam int PRIO_A   = 0;
  localparam int PRIO_B   = 1;

endpackage

// File: rtl/dpram_port_rd.sv
// rtl/dpram_port_rd.sv - per-port read register, valid pulse and read-during-write bypass
module dpram_port_rd
  import dpram_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int RD_MODE = RD_FIRST
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rd,
  input  logic              i_in_range,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_byp_hit,
  input  logic [DATA_W-1:0] i_byp_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid
);

  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  // Out-of-range reads still complete, but return zero instead of a stored word.
  always_comb begin
    w_word = i_mem_data;
    if (!i_in_range) begin
      w_word = '0;
    end else if ((RD_MODE == WR_FIRST) && i_byp_hit) begin
      w_word = i_byp_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_rd;
      if (i_rd) begin
        r_data <= w_word;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/dual_port_ram_param.sv
// rtl/dual_port_ram_param.sv - parametrised true dual-port RAM with clear-after-reset,
// write-write arbitration and selectable read-during-write policy
module dual_port_ram_param
  import dpram_pkg::*;
#(
  parameter int              DATA_W   = 8,
  parameter int              DEPTH    = 8,
  parameter int              ADDR_W   = $clog2(DEPTH),
  parameter int              RD_MODE  = RD_FIRST,
  parameter int              WR_PRIO  = PRIO_A,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_a_i,
  input  logic              we_a_i,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic [DATA_W-1:0] data_a_i,
  output logic [DATA_W-1:0] data_a_o,
  output logic              valid_a_o,
  input  logic              en_b_i,
  input  logic              we_b_i,
  input  logic [ADDR_W-1:0] addr_b_i,
  input  logic [DATA_W-1:0] data_b_i,
  output logic [DATA_W-1:0] data_b_o,
  output logic              valid_b_o,
  output logic              busy_o,
  output logic              collision_o
);

  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W + 1)'(DEPTH);

  dpram_state_e      r_state;
  dpram_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_coll;

  logic              w_ready;
  logic              w_in_a, w_in_b;
  logic              w_req_a, w_req_b;
  logic              w_ww_same;
  logic              w_wr_a, w_wr_b;
  logic              w_rd_a, w_rd_b;
  logic [DATA_W-1:0] w_mem_a, w_mem_b;

  assign w_ready = (r_state == READY);
  assign w_in_a  = ({1'b0, addr_a_i} < LP_DEPTH);
  assign w_in_b  = ({1'b0, addr_b_i} < LP_DEPTH);

  assign w_req_a   = w_ready & en_a_i & we_a_i & w_in_a;
  assign w_req_b   = w_ready & en_b_i & we_b_i & w_in_b;
  assign w_ww_same = w_req_a & w_req_b & (addr_a_i == addr_b_i);

  // On a same-address write pair only the priority port reaches the array.
  assign w_wr_a = w_req_a & ~(w_ww_same & (WR_PRIO == PRIO_B));
  assign w_wr_b = w_req_b & ~(w_ww_same & (WR_PRIO == PRIO_A));

  assign w_rd_a = w_ready & en_a_i & ~we_a_i;
  assign w_rd_b = w_ready & en_b_i & ~we_b_i;

  always_comb begin
    w_mem_a = '0;
    w_mem_b = '0;
    if (w_in_a) begin
      w_mem_a = r_mem[addr_a_i];
    end
    if (w_in_b) begin
      w_mem_b = r_mem[addr_b_i];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == CLEAR) && (r_cnt == LP_LAST)) begin
      w_state_nxt = READY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_coll  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_coll  <= w_ww_same;
      if (r_state == CLEAR) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (r_state == CLEAR) begin
        r_mem[r_cnt] <= INIT_VAL;
      end else begin
        if (w_wr_a) begin
          r_mem[addr_a_i] <= data_a_i;
        end
        if (w_wr_b) begin
          r_mem[addr_b_i] <= data_b_i;
        end
      end
    end
  end

  dpram_port_rd #(
    .DATA_W  (DATA_W),
    .RD_MODE (RD_MODE)
  ) u_rd_a (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_rd       (w_rd_a),
    .i_in_range (w_in_a),
    .i_mem_data (w_mem_a),
    .i_byp_hit  (w_wr_b & (addr_b_i == addr_a_i)),
    .i_byp_data (data_b_i),
    .o_data     (data_a_o),
    .o_valid    (valid_a_o)
  );

  dpram_port_rd #(
    .DATA_W  (DATA_W),
    .RD_MODE (RD_MODE)
  ) u_rd_b (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_rd       (w_rd_b),
    .i_in_range (w_in_b),
    .i_mem_data (w_mem_b),
    .i_byp_hit  (w_wr_a & (addr_a_i == addr_b_i)),
    .i_byp_data (data_a_i),
    .o_data     (data_b_o),
    .o_valid    (valid_b_o)
  );

  assign busy_o      = (r_state == CLEAR);
  assign collision_o = r_coll;

endmodule
